// File: rtl/seq_divider.sv
// Multi-cycle radix-2 non-restoring divider with a start/done handshake.
// Signed operands are divided as magnitudes; signs are restored in the FIX cycle.
module seq_divider #(
  parameter int word_size = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 signed_op,
  input  logic [word_size-1:0] dividend,
  input  logic [word_size-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [word_size-1:0] quotient,
  output logic [word_size-1:0] remainder
);

  localparam int cw = $clog2(word_size);
  localparam logic [word_size-1:0] one = {{(word_size-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t state, state_next;

  logic [word_size:0]   p;
  logic [word_size-1:0] a;
  logic [word_size-1:0] d;
  logic [cw-1:0]        count;
  logic                 neg_n;
  logic                 neg_d;
  logic                 zero_pend;

  logic                 accept;
  logic                 in_neg_n;
  logic                 in_neg_d;
  logic [word_size-1:0] abs_n;
  logic [word_size-1:0] abs_d;
  logic [word_size:0]   d_ext;
  logic [word_size:0]   p_shift;
  logic [word_size:0]   p_step;
  logic [word_size:0]   p_fix;
  logic [word_size-1:0] q_fix;
  logic [word_size-1:0] r_fix;

  assign accept   = (state == IDLE) && start;
  assign in_neg_n = signed_op && dividend[word_size-1];
  assign in_neg_d = signed_op && divisor[word_size-1];
  assign abs_n    = in_neg_n ? (~dividend + one) : dividend;
  assign abs_d    = in_neg_d ? (~divisor + one) : divisor;

  // One non-restoring step: add or subtract D depending on the sign of P before the shift.
  assign d_ext   = {1'b0, d};
  assign p_shift = {p[word_size-1:0], a[word_size-1]};
  assign p_step  = p[word_size] ? (p_shift + d_ext) : (p_shift - d_ext);

  assign p_fix = p[word_size] ? (p + d_ext) : p;
  assign q_fix = (neg_n ^ neg_d) ? (~a + one) : a;
  assign r_fix = neg_n ? (~p_fix[word_size-1:0] + one) : p_fix[word_size-1:0];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (divisor == '0) ? DONE : RUN;
      RUN:  if (count == '0) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = zero_pend ? DONE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A divide-by-zero spends one busy cycle in DONE before the done pulse.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN, FIX: busy = 1'b1;
      DONE: begin
        busy = zero_pend;
        done = ~zero_pend;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      p           <= '0;
      a           <= '0;
      d           <= '0;
      count       <= '0;
      neg_n       <= 1'b0;
      neg_d       <= 1'b0;
      zero_pend   <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            neg_n       <= in_neg_n;
            neg_d       <= in_neg_d;
            d           <= abs_d;
            p           <= '0;
            count       <= cw'(word_size - 1);
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              a         <= dividend;
              zero_pend <= 1'b1;
            end else begin
              a         <= abs_n;
            end
          end
        end
        RUN: begin
          p <= p_step;
          a <= {a[word_size-2:0], ~p_step[word_size]};
          if (count != '0) count <= count - cw'(1);
        end
        FIX: begin
          p         <= p_fix;
          quotient  <= q_fix;
          remainder <= r_fix;
        end
        DONE: begin
          if (zero_pend) begin
            zero_pend   <= 1'b0;
            quotient    <= '1;
            remainder   <= a;
            div_by_zero <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized scoreboard bench for seq_divider: the driver queues expected results
// from an arithmetic model, and a monitor checks every done pulse against the queue.
module tb_seq_divider;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    logic [31:0]  due;
  } exp_t;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  exp_t sb[$];

  seq_divider #(.word_size(W)) dut (
    .clk(clk),
    .clr(clr),
    .start(start),
    .signed_op(signed_op),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .quotient(quotient),
    .remainder(remainder)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference result from plain integer arithmetic (SV division truncates toward zero).
  function automatic exp_t model(input logic sgn, input logic [W-1:0] n, input logic [W-1:0] dv);
    exp_t   e;
    longint sn;
    longint sd;
    longint tq;
    longint tr;
    e = '0;
    if (dv == '0) begin
      e.q = '1;
      e.r = n;
      e.z = 1'b1;
    end else if (sgn) begin
      sn  = $signed(n);
      sd  = $signed(dv);
      tq  = sn / sd;
      tr  = sn % sd;
      e.q = tq[W-1:0];
      e.r = tr[W-1:0];
    end else begin
      e.q = n / dv;
      e.r = n % dv;
    end
    return e;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (!clr && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cycle);
      end else begin
        e = sb.pop_front();
        check_output("quotient", quotient, e.q);
        check_output("remainder", remainder, e.r);
        check_output("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.z});
        check_output("done_latency", cycle, e.due);
        check_output("busy_on_done", {31'b0, busy}, 32'd0);
      end
    end
  end

  // Issue one divide, optionally pulsing start again at two cycles of the operation.
  task automatic apply_stimulus(input logic sgn, input logic [W-1:0] n, input logic [W-1:0] dv,
                                input int pulse_a, input int pulse_b);
    exp_t e;
    logic seen;
    logic busy_ok;
    @(negedge clk);
    start     = 1'b1;
    signed_op = sgn;
    dividend  = n;
    divisor   = dv;
    @(posedge clk);
    #1;
    start = 1'b0;
    e     = model(sgn, n, dv);
    e.due = cycle + ((dv == '0) ? 1 : W + 1);
    sb.push_back(e);
    seen    = 1'b0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) check_output("dbz_cleared_on_start", {31'b0, div_by_zero}, 32'd0);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (k == pulse_a || k == pulse_b) begin
        start     = 1'b1;
        signed_op = 1'($urandom);
        dividend  = $urandom;
        divisor   = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout actual=0 expected=1 (cycle %0d)", cycle);
    end
    check_output("busy_while_running", {31'b0, busy_ok}, 32'd1);
    @(posedge clk);
  endtask

  initial begin
    logic [W-1:0] n;
    logic [W-1:0] dv;
    logic         sgn;

    repeat (3) @(negedge clk);
    check_output("reset_busy", {31'b0, busy}, 32'd0);
    check_output("reset_done", {31'b0, done}, 32'd0);
    check_output("reset_dbz", {31'b0, div_by_zero}, 32'd0);
    check_output("reset_quotient", quotient, 32'd0);
    check_output("reset_remainder", remainder, 32'd0);
    clr = 1'b0;
    @(posedge clk);

    apply_stimulus(1'b0, 32'd100, 32'd7, 0, 0);
    apply_stimulus(1'b1, -32'sd100, 32'd7, 0, 0);
    apply_stimulus(1'b1, 32'd100, -32'sd7, 0, 0);
    apply_stimulus(1'b1, -32'sd100, -32'sd7, 0, 0);
    apply_stimulus(1'b0, 32'h0000_1234, 32'd0, 0, 0);
    apply_stimulus(1'b0, 32'd50, 32'd5, 0, 0);
    apply_stimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    apply_stimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0);
    apply_stimulus(1'b0, 32'd5, 32'd9, 0, 0);
    apply_stimulus(1'b1, 32'hFFFF_FF00, 32'd0, 0, 0);
    apply_stimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    apply_stimulus(1'b0, 32'd12345, 32'd67, 5, 33);
    apply_stimulus(1'b1, 32'd999, -32'sd10, 0, 0);

    // Abort an operation with a short asynchronous reset pulse.
    apply_stimulus(1'b0, 32'd1000, 32'd7, 0, 0);
    @(negedge clk);
    start     = 1'b1;
    signed_op = 1'b0;
    dividend  = 32'd555;
    divisor   = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    check_output("abort_busy", {31'b0, busy}, 32'd0);
    check_output("abort_done", {31'b0, done}, 32'd0);
    check_output("abort_dbz", {31'b0, div_by_zero}, 32'd0);
    check_output("abort_quotient", quotient, 32'd0);
    check_output("abort_remainder", remainder, 32'd0);
    #1 clr = 1'b0;
    repeat (45) @(negedge clk);
    apply_stimulus(1'b0, 32'd81, 32'd9, 0, 0);

    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom);
      n   = $urandom;
      case ($urandom_range(0, 5))
        0:       dv = '0;
        1:       dv = 32'($urandom_range(1, 15));
        2:       dv = 32'hFFFF_FFFF;
        3:       dv = $urandom >> $urandom_range(0, 31);
        default: dv = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) n = 32'h8000_0000;
      apply_stimulus(sgn, n, dv, (i % 4 == 0) ? 7 : 0, 0);
    end

    repeat (5) @(negedge clk);
    check_output("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
